trans_feeder: RTL and testbench
===============================

Name: trans_feeder

Overview:
- Initiator side of the 128-bit transaction handshake: assembles transactions from an 8-bit byte stream, buffers whole words, and presents them one at a time to the transaction validator.
- Drives data/valid and holds them until the validator's single-cycle ack.
- Sits between the host byte link (UART/PCIe byte adapter) and the validator input.

Parameters:
- WORD_BYTES, 16, bytes per transaction word; word width = 8*WORD_BYTES.
- FIFO_DEPTH, 4, completed words buffered; power of 2, >= 2.
- ACK_TIMEOUT, 8192, cycles in PRESENT without ack before timeout_o is set.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- byte_i  in  8  stream byte.
- byte_valid_i  in  1  byte_i is valid.
- sof_i  in  1  qualifies the accepted byte as byte 0 of a word.
- byte_ready_o  out  1  byte accepted on a cycle when byte_valid_i && byte_ready_o.
- data_o  out  128  transaction word to the validator.
- valid_o  out  1  data_o valid; held until ack.
- ack_i  in  1  one-cycle acknowledge from the validator.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  words currently buffered.
- sent_count_o  out  32  acked transactions, wraps modulo 2^32.
- frame_err_o  out  1  sticky: sof_i seen mid-word.
- timeout_o  out  1  sticky: ACK_TIMEOUT reached.

Behaviour:
- Reset is synchronous and active-high; clk is the only clock. On rst: valid_o=0, data_o=0, fifo empty, fifo_level_o=0, sent_count_o=0, frame_err_o=0, timeout_o=0, byte counter=0, FSM=IDLE. If rst is asserted mid-presentation, valid_o is low on the next cycle and the word is lost.
- Assembly:
  - Byte k (0..15) fills bits [127-8k -: 8]; byte 0 is the MSB. Fields: sender [127:80], receiver [79:32], amount [31:10], block_start bit 9.
  - The byte counter increments on each accepted byte. On the 16th byte the complete word is written to the FIFO on that edge, and the counter returns to 0.
  - sof_i on an accepted byte with counter != 0: discard the partial word, set frame_err_o, store the byte as byte 0, counter=1. sof_i with counter==0 has no special effect.
- byte_ready_o = !fifo_full. Bytes are not accepted while the FIFO is full, including bytes 0..14.
- FIFO: synchronous, first-word-fall-through head. Push and pop on the same edge are legal at any level, including full.
- Handshake FSM (IDLE, PRESENT, GAP):
  - IDLE: if the FIFO is not empty, load the head into data_o, pop, set valid_o=1, go to PRESENT.
  - PRESENT: data_o and valid_o are held stable and the timeout counter increments.
    - If ack_i: valid_o=0 on the next edge, sent_count_o+1, clear the timeout counter, go to GAP.
    - If the counter reaches ACK_TIMEOUT: set timeout_o, keep presenting.
  - GAP: one cycle with valid_o=0, then go to IDLE. Minimum spacing is one low cycle between words.
- Latency: the 16th byte is accepted at edge N; valid_o is high after edge N+1 when the FSM is IDLE.
- ack_i in IDLE or GAP is ignored.
- data_o holds its last value while valid_o=0. It changes only on an IDLE load or reset.
- No payload modification; block_start bit 9 is forwarded as received.

Decomposition:
- Package trans_pkg: WORD_W=128, field ranges (SENDER_MSB/LSB 127/80, RECEIVER 79/32, AMOUNT 31/10, BIT_BLOCK_START 9), FSM state enum feeder_state_t. The validator also uses this package.
- One sub-module: trans_word_fifo (parameterised width/depth sync FIFO with level, full, empty).
- The assembler and FSM stay in trans_feeder.

Test Plan:
- Reset, then 16 bytes 0x00..0x0F with sof_i on byte 0 -> valid_o rises 2 edges after the last byte; data_o=128'h000102030405060708090A0B0C0D0E0F; ack_i pulsed 3 cycles later -> valid_o low next cycle, sent_count_o=1.
- Stream 6 words with no ack -> byte_ready_o drops once 4 words are buffered and the 5th word is in the FSM; fifo_level_o=4. Ack each word after 20 cycles -> all 6 words emitted in order, at least 1 low valid cycle between them, sent_count_o=6.
- sof_i on byte 7 of a word -> frame_err_o=1; the partial word is never emitted; the next 16 bytes form a correct word.
- Hold ack low for 8192 cycles in PRESENT -> timeout_o=1 at cycle 8192, valid_o still high and data_o unchanged. A later ack is accepted normally.
- Assert rst while valid_o=1 and 2 words are buffered -> valid_o=0, fifo_level_o=0, sent_count_o=0 next cycle; no stale word after reset.
- ack_i pulsed in IDLE with an empty FIFO -> no state change, sent_count_o unchanged.

Source files
------------

// File: rtl/trans_feeder_pkg.sv
// Shared definitions for the 128-bit transaction path: word layout, field
// positions and the feeder handshake state encoding (also used by the validator).
package trans_pkg;

  localparam int WORD_W          = 128;

  localparam int SENDER_MSB      = 127;
  localparam int SENDER_LSB      = 80;
  localparam int RECEIVER_MSB    = 79;
  localparam int RECEIVER_LSB    = 32;
  localparam int AMOUNT_MSB      = 31;
  localparam int AMOUNT_LSB      = 10;
  localparam int BIT_BLOCK_START = 9;

  typedef enum logic [1:0] {
    FEED_IDLE    = 2'd0,
    FEED_PRESENT = 2'd1,
    FEED_GAP     = 2'd2
  } feeder_state_t;

  function automatic logic get_block_start(input logic [WORD_W-1:0] word);
    return word[BIT_BLOCK_START];
  endfunction

endpackage

// File: rtl/trans_word_fifo.sv
// Synchronous word FIFO with a fall-through head; simultaneous push and pop
// are accepted at every level, including full.
module trans_word_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign head_o  = mem[rdPtr_q];
  assign level_o = level_q;

  // A pop frees the slot a same-edge push lands in, so full does not block it.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({doPush, doPop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/trans_feeder.sv
// Initiator side of the transaction handshake: packs host bytes into words,
// buffers them and presents each one to the validator until it is acknowledged.
module trans_feeder
  import trans_pkg::*;
#(
  parameter int WORD_BYTES  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 8192
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    byte_i,
  input  logic                          byte_valid_i,
  input  logic                          sof_i,
  output logic                          byte_ready_o,
  output logic [8*WORD_BYTES-1:0]       data_o,
  output logic                          valid_o,
  input  logic                          ack_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [31:0]                   sent_count_o,
  output logic                          frame_err_o,
  output logic                          timeout_o
);

  localparam int WW    = 8 * WORD_BYTES;
  localparam int CNT_W = $clog2(WORD_BYTES);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0]  byteCnt_q, byteCnt_d;
  logic [WW-1:0]     asmWord_q, asmWord_d;
  logic              frameErr_q, frameErr_d;
  logic              byteAccept;
  logic              push;

  feeder_state_t     state_q, state_d;
  logic [WW-1:0]     data_q, data_d;
  logic              valid_q, valid_d;
  logic [31:0]       sentCnt_q, sentCnt_d;
  logic [TMO_W-1:0]  tmoCnt_q, tmoCnt_d;
  logic              timeout_q, timeout_d;
  logic              pop;

  logic [WW-1:0]     fifoHead;
  logic              fifoFull;
  logic              fifoEmpty;

  assign byte_ready_o = !fifoFull;
  assign byteAccept   = byte_valid_i && byte_ready_o;

  // The word handed to the FIFO is asmWord_d so the final byte is included
  // on the same edge it is accepted.
  always_comb begin
    asmWord_d  = asmWord_q;
    byteCnt_d  = byteCnt_q;
    frameErr_d = frameErr_q;
    push       = 1'b0;
    if (byteAccept) begin
      if (sof_i && (byteCnt_q != '0)) begin
        frameErr_d         = 1'b1;
        asmWord_d          = '0;
        asmWord_d[WW-1 -: 8] = byte_i;
        byteCnt_d          = CNT_W'(1);
      end else begin
        asmWord_d[WW-1-8*int'(byteCnt_q) -: 8] = byte_i;
        if (byteCnt_q == CNT_W'(WORD_BYTES - 1)) begin
          push      = 1'b1;
          byteCnt_d = '0;
        end else begin
          byteCnt_d = byteCnt_q + CNT_W'(1);
        end
      end
    end
  end

  trans_word_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (asmWord_d),
    .pop_i       (pop),
    .head_o      (fifoHead),
    .level_o     (fifo_level_o),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty)
  );

  // Timeout counter saturates at ACK_TIMEOUT so the sticky flag never re-arms by wrap.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    sentCnt_d = sentCnt_q;
    tmoCnt_d  = '0;
    timeout_d = timeout_q;
    pop       = 1'b0;
    case (state_q)
      FEED_IDLE: begin
        valid_d = 1'b0;
        if (!fifoEmpty) begin
          data_d  = fifoHead;
          pop     = 1'b1;
          valid_d = 1'b1;
          state_d = FEED_PRESENT;
        end
      end
      FEED_PRESENT: begin
        if (ack_i) begin
          valid_d   = 1'b0;
          sentCnt_d = sentCnt_q + 32'd1;
          state_d   = FEED_GAP;
        end else begin
          if (tmoCnt_q == TMO_W'(ACK_TIMEOUT)) begin
            tmoCnt_d = tmoCnt_q;
          end else begin
            tmoCnt_d = tmoCnt_q + TMO_W'(1);
          end
          if (tmoCnt_q >= TMO_W'(ACK_TIMEOUT - 1)) begin
            timeout_d = 1'b1;
          end
        end
      end
      FEED_GAP: begin
        valid_d = 1'b0;
        state_d = FEED_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = FEED_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byteCnt_q  <= '0;
      asmWord_q  <= '0;
      frameErr_q <= 1'b0;
      state_q    <= FEED_IDLE;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sentCnt_q  <= '0;
      tmoCnt_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      byteCnt_q  <= byteCnt_d;
      asmWord_q  <= asmWord_d;
      frameErr_q <= frameErr_d;
      state_q    <= state_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sentCnt_q  <= sentCnt_d;
      tmoCnt_q   <= tmoCnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign sent_count_o = sentCnt_q;
  assign frame_err_o  = frameErr_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_trans_feeder.sv
// Directed self-checking bench for trans_feeder: latency, back-pressure,
// framing errors, ack timeout and mid-presentation reset.
module tb_trans_feeder;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   byte_i;
  logic         byte_valid_i;
  logic         sof_i;
  logic         byte_ready_o;
  logic [127:0] data_o;
  logic         valid_o;
  logic         ack_i;
  logic [2:0]   fifo_level_o;
  logic [31:0]  sent_count_o;
  logic         frame_err_o;
  logic         timeout_o;

  int compCnt = 0;
  int failCnt = 0;

  localparam logic [127:0] W0  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] W1  = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] W2  = 128'h202122232425262728292A2B2C2D2E2F;
  localparam logic [127:0] W3  = 128'h303132333435363738393A3B3C3D3E3F;
  localparam logic [127:0] W4  = 128'h404142434445464748494A4B4C4D4E4F;
  localparam logic [127:0] W5  = 128'h505152535455565758595A5B5C5D5E5F;
  localparam logic [127:0] W6  = 128'h606162636465666768696A6B6C6D6E6F;
  localparam logic [127:0] W7  = 128'hDEADBEEFCAFE0123456789AB00000E00;
  localparam logic [127:0] W8  = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] W9  = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
  localparam logic [127:0] W10 = 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A;
  localparam logic [127:0] W11 = 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F;

  logic [127:0] drainQ [5];

  always #5 clk = ~clk;

  trans_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .sof_i        (sof_i),
    .byte_ready_o (byte_ready_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ack_i        (ack_i),
    .fifo_level_o (fifo_level_o),
    .sent_count_o (sent_count_o),
    .frame_err_o  (frame_err_o),
    .timeout_o    (timeout_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic s);
    int n;
    byte_i       = b;
    sof_i        = s;
    byte_valid_i = 1'b1;
    n = 0;
    while (!byte_ready_o && n < 200) begin
      tick();
      n++;
    end
    if (n == 200) checkOutput("byteReadyWait", {127'b0, byte_ready_o}, 128'd1);
    tick();
    byte_valid_i = 1'b0;
    sof_i        = 1'b0;
  endtask

  task automatic sendWord(input logic [127:0] w);
    for (int k = 0; k < 16; k++) applyStimulus(w[127-8*k -: 8], k == 0);
  endtask

  task automatic ackPulse();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    drainQ = '{W2, W3, W4, W5, W6};
    rst = 1'b1; byte_i = 8'h00; byte_valid_i = 1'b0; sof_i = 1'b0; ack_i = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    checkOutput("rstValid",   {127'b0, valid_o},      128'd0);
    checkOutput("rstData",    data_o,                 128'd0);
    checkOutput("rstLevel",   {125'b0, fifo_level_o}, 128'd0);
    checkOutput("rstSent",    {96'b0, sent_count_o},  128'd0);
    checkOutput("rstFrame",   {127'b0, frame_err_o},  128'd0);
    checkOutput("rstTimeout", {127'b0, timeout_o},    128'd0);
    checkOutput("rstReady",   {127'b0, byte_ready_o}, 128'd1);

    // First word: latency and basic ack.
    sendWord(W0);
    checkOutput("w0ValidEarly", {127'b0, valid_o}, 128'd0);
    tick();
    checkOutput("w0Valid", {127'b0, valid_o}, 128'd1);
    checkOutput("w0Data",  data_o,            W0);
    repeat (2) tick();
    checkOutput("w0Held",  data_o,            W0);
    ackPulse();
    checkOutput("w0AckValid", {127'b0, valid_o},     128'd0);
    checkOutput("w0AckSent",  {96'b0, sent_count_o}, 128'd1);
    tick();

    // Ack with nothing presented is ignored.
    ackPulse();
    checkOutput("idleAckSent",  {96'b0, sent_count_o}, 128'd1);
    checkOutput("idleAckValid", {127'b0, valid_o},     128'd0);
    checkOutput("idleAckData",  data_o,                W0);
    tick();

    // Back-pressure: one word presented, four buffered.
    sendWord(W1); sendWord(W2); sendWord(W3); sendWord(W4); sendWord(W5);
    checkOutput("fullLevel", {125'b0, fifo_level_o}, 128'd4);
    checkOutput("fullReady", {127'b0, byte_ready_o}, 128'd0);
    checkOutput("fullValid", {127'b0, valid_o},      128'd1);
    checkOutput("fullData",  data_o,                 W1);
    byte_i = 8'h60; sof_i = 1'b1; byte_valid_i = 1'b1;
    repeat (3) tick();
    checkOutput("stallLevel", {125'b0, fifo_level_o}, 128'd4);
    byte_valid_i = 1'b0; sof_i = 1'b0;
    repeat (17) tick();
    checkOutput("w1Held", data_o, W1);
    ackPulse();
    checkOutput("w1AckValid", {127'b0, valid_o},     128'd0);
    checkOutput("w1AckSent",  {96'b0, sent_count_o}, 128'd2);
    tick();
    checkOutput("w1GapValid", {127'b0, valid_o}, 128'd0);
    tick();
    checkOutput("w2Load",  data_o,                 W2);
    checkOutput("w2Level", {125'b0, fifo_level_o}, 128'd3);
    checkOutput("w2Ready", {127'b0, byte_ready_o}, 128'd1);
    sendWord(W6);
    checkOutput("w6Level", {125'b0, fifo_level_o}, 128'd4);

    for (int i = 0; i < 5; i++) begin
      repeat (20) tick();
      checkOutput($sformatf("drainValid%0d", i), {127'b0, valid_o}, 128'd1);
      checkOutput($sformatf("drainData%0d", i),  data_o,            drainQ[i]);
      ackPulse();
      checkOutput($sformatf("drainSent%0d", i),  {96'b0, sent_count_o}, 128'(3 + i));
      checkOutput($sformatf("drainLow%0d", i),   {127'b0, valid_o},     128'd0);
      tick();
      checkOutput($sformatf("drainGap%0d", i),   {127'b0, valid_o},     128'd0);
      tick();
    end
    checkOutput("drainEmptyValid", {127'b0, valid_o},      128'd0);
    checkOutput("drainEmptyLevel", {125'b0, fifo_level_o}, 128'd0);

    // Framing error: partial word discarded, next word intact.
    for (int k = 0; k < 7; k++) applyStimulus(8'hEE, k == 0);
    checkOutput("preFrameErr", {127'b0, frame_err_o}, 128'd0);
    sendWord(W7);
    checkOutput("frameErr",    {127'b0, frame_err_o}, 128'd1);
    checkOutput("frameNoEmit", {127'b0, valid_o},     128'd0);
    tick();
    checkOutput("w7Valid", {127'b0, valid_o},      128'd1);
    checkOutput("w7Data",  data_o,                 W7);
    checkOutput("w7Level", {125'b0, fifo_level_o}, 128'd0);
    ackPulse();
    checkOutput("w7Sent", {96'b0, sent_count_o}, 128'd8);
    tick();

    // Ack timeout while presenting.
    sendWord(W8);
    tick();
    checkOutput("w8Data", data_o, W8);
    repeat (8191) tick();
    checkOutput("tmoBefore", {127'b0, timeout_o}, 128'd0);
    tick();
    checkOutput("tmoSet",   {127'b0, timeout_o}, 128'd1);
    checkOutput("tmoValid", {127'b0, valid_o},   128'd1);
    checkOutput("tmoData",  data_o,              W8);
    ackPulse();
    checkOutput("tmoAckSent",  {96'b0, sent_count_o}, 128'd9);
    checkOutput("tmoAckValid", {127'b0, valid_o},     128'd0);
    checkOutput("tmoSticky",   {127'b0, timeout_o},   128'd1);
    tick();

    // Reset during presentation with two words buffered.
    sendWord(W9);
    tick();
    sendWord(W10);
    sendWord(W11);
    checkOutput("preRstLevel", {125'b0, fifo_level_o}, 128'd2);
    checkOutput("preRstData",  data_o,                 W9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midRstValid",   {127'b0, valid_o},      128'd0);
    checkOutput("midRstLevel",   {125'b0, fifo_level_o}, 128'd0);
    checkOutput("midRstSent",    {96'b0, sent_count_o},  128'd0);
    checkOutput("midRstFrame",   {127'b0, frame_err_o},  128'd0);
    checkOutput("midRstTimeout", {127'b0, timeout_o},    128'd0);
    checkOutput("midRstData",    data_o,                 128'd0);
    repeat (4) tick();
    checkOutput("postRstStale", {127'b0, valid_o}, 128'd0);
    sendWord(W0);
    tick();
    checkOutput("postRstData", data_o, W0);
    ackPulse();
    checkOutput("postRstSent", {96'b0, sent_count_o}, 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
    $finish;
  end

endmodule
